// File: rtl/dff_share_arbiter.sv
// dff_share_arbiter: round-robin arbiter that owns the only write path into a
// shared WIDTH-bit register. One requester is granted at a time. A grantee may
// lock ownership for up to MAX_HOLD consecutive writes, and every release
// passes through an IDLE cycle before the next grant.
module dff_share_arbiter #(
   parameter int NREQ     = 4,
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          lock,
   input  logic [NREQ*WIDTH-1:0]    wdata,
   output logic [NREQ-1:0]          gnt,
   output logic [$clog2(NREQ)-1:0]  owner,
   output logic [WIDTH-1:0]         q,
   output logic                     upd
);

   localparam int IW = $clog2(NREQ);
   localparam int HW = $clog2(MAX_HOLD) + 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   state_t          state_r, state_d;
   logic [NREQ-1:0] gnt_r, gnt_d;
   logic [IW-1:0]   owner_r, owner_d;
   logic [WIDTH-1:0] q_r, q_d;
   logic            upd_r, upd_d;
   logic [IW-1:0]   ptr_r, ptr_d;
   logic [HW-1:0]   hold_r, hold_d;

   logic            found;
   logic [IW-1:0]   sel;
   logic [IW-1:0]   idx;

   // Search for the first requester at or after ptr, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      sel   = ptr_r;
      idx   = ptr_r;
      for (int k = 0; k < NREQ; k++) begin
         idx = ptr_r + IW'(k);
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   // Next-state and next-output logic for the IDLE/OWN ownership FSM.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d = state_r;
      gnt_d   = gnt_r;
      owner_d = owner_r;
      q_d     = q_r;
      upd_d   = 1'b0;
      ptr_d   = ptr_r;
      hold_d  = hold_r;

      unique case (state_r)
         IDLE: begin
            if (found) begin
               gnt_d   = NREQ'(1) << sel;
               owner_d = sel;
               hold_d  = '0;
               state_d = OWN;
            end else begin
               gnt_d = '0;
            end
         end
         OWN: begin
            if (!req[owner_r]) begin
               // Owner withdrew: release without writing.
               gnt_d   = '0;
               ptr_d   = owner_r + IW'(1);
               state_d = IDLE;
            end else begin
               q_d   = wdata[owner_r*WIDTH +: WIDTH];
               upd_d = 1'b1;
               if (!lock[owner_r] || hold_r == HOLD_LAST) begin
                  gnt_d   = '0;
                  ptr_d   = owner_r + IW'(1);
                  state_d = IDLE;
               end else begin
                  hold_d = hold_r + HW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_r <= IDLE;
         gnt_r   <= '0;
         owner_r <= '0;
         q_r     <= '0;
         upd_r   <= 1'b0;
         ptr_r   <= '0;
         hold_r  <= '0;
      end else begin
         state_r <= state_d;
         gnt_r   <= gnt_d;
         owner_r <= owner_d;
         q_r     <= q_d;
         upd_r   <= upd_d;
         ptr_r   <= ptr_d;
         hold_r  <= hold_d;
      end
   end

   assign gnt   = gnt_r;
   assign owner = owner_r;
   assign q     = q_r;
   assign upd   = upd_r;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Directed bench for dff_share_arbiter (NREQ=4, WIDTH=8, MAX_HOLD=4).
module tb_dff_share_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  lock;
   logic [31:0] wdata;
   logic [3:0]  gnt;
   logic [1:0]  owner;
   logic [7:0]  q;
   logic        upd;

   int n_tests = 0;
   int n_fail  = 0;

   dff_share_arbiter #(.NREQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .lock  (lock),
      .wdata (wdata),
      .gnt   (gnt),
      .owner (owner),
      .q     (q),
      .upd   (upd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  lock;
      logic [31:0] wdata;
      logic [3:0]  gnt;
      logic [1:0]  owner;
      logic [7:0]  q;
      logic        upd;
   } vec_t;

   vec_t vecs[19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      req = '0; lock = '0; wdata = '0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      // Single beat, ptr advance, lock on non-owner ignored, then round robin.
      vecs[0]  = '{4'b0001, 4'b0000, 32'h403020A5, 4'b0001, 2'd0, 8'h00, 1'b0};
      vecs[1]  = '{4'b0001, 4'b0000, 32'h403020A5, 4'b0000, 2'd0, 8'hA5, 1'b1};
      vecs[2]  = '{4'b0000, 4'b0000, 32'h403020A5, 4'b0000, 2'd0, 8'hA5, 1'b0};
      vecs[3]  = '{4'b0011, 4'b0001, 32'h40302010, 4'b0010, 2'd1, 8'hA5, 1'b0};
      vecs[4]  = '{4'b0011, 4'b0001, 32'h40302010, 4'b0000, 2'd1, 8'h20, 1'b1};
      vecs[5]  = '{4'b1100, 4'b0000, 32'h40302010, 4'b0100, 2'd2, 8'h20, 1'b0};
      vecs[6]  = '{4'b1100, 4'b0000, 32'h40302010, 4'b0000, 2'd2, 8'h30, 1'b1};
      vecs[7]  = '{4'b1000, 4'b0000, 32'h40302010, 4'b1000, 2'd3, 8'h30, 1'b0};
      vecs[8]  = '{4'b1000, 4'b0000, 32'h40302010, 4'b0000, 2'd3, 8'h40, 1'b1};
      vecs[9]  = '{4'b1111, 4'b0000, 32'h40302010, 4'b0001, 2'd0, 8'h40, 1'b0};
      vecs[10] = '{4'b1111, 4'b0000, 32'h40302010, 4'b0000, 2'd0, 8'h10, 1'b1};
      vecs[11] = '{4'b1111, 4'b0000, 32'h40302010, 4'b0010, 2'd1, 8'h10, 1'b0};
      vecs[12] = '{4'b1111, 4'b0000, 32'h40302010, 4'b0000, 2'd1, 8'h20, 1'b1};
      vecs[13] = '{4'b1111, 4'b0000, 32'h40302010, 4'b0100, 2'd2, 8'h20, 1'b0};
      vecs[14] = '{4'b1111, 4'b0000, 32'h40302010, 4'b0000, 2'd2, 8'h30, 1'b1};
      vecs[15] = '{4'b1111, 4'b0000, 32'h40302010, 4'b1000, 2'd3, 8'h30, 1'b0};
      vecs[16] = '{4'b1111, 4'b0000, 32'h40302010, 4'b0000, 2'd3, 8'h40, 1'b1};
      vecs[17] = '{4'b1111, 4'b0000, 32'h40302010, 4'b0001, 2'd0, 8'h40, 1'b0};
      vecs[18] = '{4'b1111, 4'b0000, 32'h40302010, 4'b0000, 2'd0, 8'h10, 1'b1};

      // Reset held with all requests high: outputs stay clear across edges.
      rst = 1'b0; req = 4'b1111; lock = '0; wdata = 32'h40302010;
      #3;
      check("rst_gnt_t3", 32'(gnt), 32'h0);
      check("rst_q_t3",   32'(q),   32'h0);
      check("rst_upd_t3", 32'(upd), 32'h0);
      #9;
      check("rst_gnt_t12", 32'(gnt), 32'h0);
      check("rst_q_t12",   32'(q),   32'h0);
      check("rst_upd_t12", 32'(upd), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      step();
      check("rst_release_gnt",   32'(gnt),   32'h1);
      check("rst_release_owner", 32'(owner), 32'h0);

      // Table-driven run from a clean reset.
      do_reset();
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         req = vecs[i].req; lock = vecs[i].lock; wdata = vecs[i].wdata;
         step();
         check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
         check($sformatf("vec%0d_q",   i), 32'(q),   32'(vecs[i].q));
         check($sformatf("vec%0d_upd", i), 32'(upd), 32'(vecs[i].upd));
         if (vecs[i].gnt != 4'b0000)
            check($sformatf("vec%0d_owner", i), 32'(owner), 32'(vecs[i].owner));
      end

      // Locked burst capped at MAX_HOLD writes, then IDLE, then requester 1.
      do_reset();
      req = 4'b0011; lock = 4'b0001; wdata = 32'h00006600;
      step();
      check("lock_grant", 32'(gnt), 32'h1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         wdata[7:0] = 8'(k);
         step();
         check($sformatf("lock_q%0d", k),   32'(q),   32'(k));
         check($sformatf("lock_upd%0d", k), 32'(upd), 32'h1);
         check($sformatf("lock_gnt%0d", k), 32'(gnt), (k < 4) ? 32'h1 : 32'h0);
      end
      @(negedge clk);
      wdata[7:0] = 8'h05;
      step();
      check("lock_next_gnt", 32'(gnt), 32'h2);
      check("lock_next_q",   32'(q),   32'h04);
      check("lock_next_upd", 32'(upd), 32'h0);
      @(negedge clk);
      wdata[7:0] = 8'h06;
      step();
      check("lock_r1_q",   32'(q),   32'h66);
      check("lock_r1_gnt", 32'(gnt), 32'h0);

      // Dropping req mid-burst releases with no write.
      do_reset();
      req = 4'b0100; lock = 4'b0100; wdata = 32'h00210000;
      step();
      check("drop_grant", 32'(gnt), 32'h4);
      step();
      check("drop_w1_q", 32'(q), 32'h21);
      @(negedge clk);
      wdata[23:16] = 8'h22;
      step();
      check("drop_w2_q",   32'(q),   32'h22);
      check("drop_w2_gnt", 32'(gnt), 32'h4);
      @(negedge clk);
      req = 4'b0000; wdata[23:16] = 8'h99;
      step();
      check("drop_q",   32'(q),   32'h22);
      check("drop_upd", 32'(upd), 32'h0);
      check("drop_gnt", 32'(gnt), 32'h0);
      step();
      check("drop_hold_q", 32'(q), 32'h22);

      // Asynchronous reset in OWN clears outputs before the next edge.
      do_reset();
      req = 4'b0001; lock = 4'b0001; wdata = 32'h0000005A;
      step();
      step();
      check("areset_pre_q",   32'(q),   32'h5A);
      check("areset_pre_gnt", 32'(gnt), 32'h1);
      #1;
      rst = 1'b0;
      #1;
      check("areset_gnt", 32'(gnt), 32'h0);
      check("areset_q",   32'(q),   32'h0);
      check("areset_upd", 32'(upd), 32'h0);
      req = 4'b1000; lock = 4'b0000;
      @(negedge clk);
      rst = 1'b1;
      step();
      check("areset_regrant_gnt",   32'(gnt),   32'h8);
      check("areset_regrant_owner", 32'(owner), 32'h3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
